// File: rtl/dec_ctrl_pkg.sv
// dec_ctrl_pkg: shared LDPC decoder constants, types and helpers.
// Also used by rd_seq for the rate-selected codeword length.
package dec_ctrl_pkg;

  localparam int FSM_LOAD = 0;
  localparam int FSM_CN   = 1;
  localparam int FSM_VN   = 2;
  localparam int FSM_OUT  = 3;

  localparam int BEATS_4608 = 128;
  localparam int BEATS_6912 = 192;
  localparam int LEN_4608   = 4608;
  localparam int LEN_6912   = 6912;

  localparam int CNT_W = 13;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    RATE_4608 = 1'b0,
    RATE_6912 = 1'b1
  } rate_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CN,
    S_VN,
    S_WAIT,
    S_OUT
  } state_e;

  function automatic cnt_t out_max(input logic rate);
    return (rate == RATE_6912) ? cnt_t'(LEN_6912 - 1)
                               : cnt_t'(LEN_4608 - 1);
  endfunction

  function automatic cnt_t beat_max(input logic rate);
    return (rate == RATE_6912) ? cnt_t'(BEATS_6912 - 1)
                               : cnt_t'(BEATS_4608 - 1);
  endfunction

endpackage

// File: rtl/dec_ctrl_if.sv
// dec_ctrl_if: control/status bundle between host logic and dec_ctrl.
// master drives requests, slave (dec_ctrl) drives phase and status.
interface dec_ctrl_if #(
  parameter int IT_WID = 6
) ();

  logic              start;
  logic              rate;
  logic [IT_WID-1:0] max_iter;
  logic              in_valid;
  logic              syn_ok;
  logic              out_ready;
  logic [3:0]        fsm;
  logic              busy;
  logic              done;
  logic              dec_ok;
  logic [IT_WID-1:0] iter_cnt;

  modport master (
    output start, rate, max_iter,
    output in_valid, syn_ok, out_ready,
    input  fsm, busy, done, dec_ok, iter_cnt
  );

  modport slave (
    input  start, rate, max_iter,
    input  in_valid, syn_ok, out_ready,
    output fsm, busy, done, dec_ok, iter_cnt
  );

endinterface

// File: rtl/dec_ctrl_phase_cnt.sv
// dec_ctrl_phase_cnt: shared 13-bit phase counter.
// Clear wins over enable; tc flags cnt == lim.
module dec_ctrl_phase_cnt
  import dec_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  cnt_t lim,
  output logic tc
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == lim);

endmodule

// File: rtl/dec_ctrl.sv
// dec_ctrl: LDPC decoder phase controller.
// Sequences LOAD, CN/VN iterations, WAIT_OUT and OUT per codeword.
module dec_ctrl
  import dec_ctrl_pkg::*;
#(
  parameter int CN_CYC = 96,
  parameter int VN_CYC = 128,
  parameter int IT_WID = 6
) (
  input logic       clk,
  input logic       reset_n,
  dec_ctrl_if.slave bus
);

  localparam logic [IT_WID-1:0] IT_ONE = IT_WID'(1);

  state_e            state_q, state_d;
  logic              rate_q, rate_d;
  logic [IT_WID-1:0] lim_q, lim_d;
  logic [IT_WID-1:0] iter_q, iter_d, iter_inc;
  logic              dec_ok_q, dec_ok_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [3:0]        fsm_q, fsm_d;

  logic cnt_clr, cnt_en, cnt_tc;
  cnt_t cnt_lim;

  assign iter_inc = iter_q + IT_ONE;

  always_comb begin
    cnt_lim = '0;
    cnt_en  = 1'b0;
    case (state_q)
      S_LOAD: begin
        cnt_lim = beat_max(rate_q);
        cnt_en  = bus.in_valid;
      end
      S_CN: begin
        cnt_lim = cnt_t'(CN_CYC - 1);
        cnt_en  = 1'b1;
      end
      S_VN: begin
        cnt_lim = cnt_t'(VN_CYC - 1);
        cnt_en  = 1'b1;
      end
      S_OUT: begin
        cnt_lim = out_max(rate_q);
        cnt_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // Restart the count on every phase change.
  assign cnt_clr = (state_d != state_q) || (state_q == S_IDLE);

  dec_ctrl_phase_cnt u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .lim     (cnt_lim),
    .tc      (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    rate_d   = rate_q;
    lim_d    = lim_q;
    iter_d   = iter_q;
    dec_ok_d = dec_ok_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_LOAD;
          rate_d   = bus.rate;
          lim_d    = (bus.max_iter == '0) ? IT_ONE : bus.max_iter;
          iter_d   = '0;
          dec_ok_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid && cnt_tc) state_d = S_CN;
      end
      S_CN: begin
        if (cnt_tc) state_d = S_VN;
      end
      S_VN: begin
        if (cnt_tc) begin
          iter_d = iter_inc;
          if (bus.syn_ok) begin
            dec_ok_d = 1'b1;
            state_d  = S_WAIT;
          end else if (iter_inc == lim_q) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_CN;
          end
        end
      end
      S_WAIT: begin
        if (bus.out_ready) state_d = S_OUT;
      end
      S_OUT: begin
        if (cnt_tc) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs follow the next state so they align with state_q.
  always_comb begin
    fsm_d = '0;
    case (state_d)
      S_LOAD:  fsm_d[FSM_LOAD] = 1'b1;
      S_CN:    fsm_d[FSM_CN]   = 1'b1;
      S_VN:    fsm_d[FSM_VN]   = 1'b1;
      S_OUT:   fsm_d[FSM_OUT]  = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rate_q   <= 1'b0;
      lim_q    <= '0;
      iter_q   <= '0;
      dec_ok_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      fsm_q    <= '0;
    end else begin
      state_q  <= state_d;
      rate_q   <= rate_d;
      lim_q    <= lim_d;
      iter_q   <= iter_d;
      dec_ok_q <= dec_ok_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      fsm_q    <= fsm_d;
    end
  end

  assign bus.fsm      = fsm_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dec_ok   = dec_ok_q;
  assign bus.iter_cnt = iter_q;

endmodule

// File: doc/dec_ctrl.md
# dec_ctrl

- Top-level phase controller for the LDPC decoder core. Sequences each codeword through four phases: load, check-node update, variable-node update, output.
- Drives the 4-bit one-hot `fsm` bus consumed by the input writer, the CN/VN processing arrays and the output read sequencer (`rd_seq`).
- Latches the code rate per codeword, counts iterations and terminates early on a zero syndrome.
- Holds the output phase for exactly one full codeword (4608 or 6912 cycles) so the output read counter wraps cleanly.

## Interface
- `CN_CYC`, default 96: cycles per check-node phase.
- `VN_CYC`, default 128: cycles per variable-node phase.
- `IT_WID`, default 6: width of the iteration counter and of `max_iter`.
- `clk` input 1: single system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request to decode a new codeword; sampled only in IDLE.
- `rate` input 1: 0 selects the 4608-bit code, 1 selects the 6912-bit code; sampled together with `start`.
- `max_iter` input IT_WID: iteration limit; a value of 0 is treated as 1.
- `in_valid` input 1: one 36-lane LLR beat is present this cycle.
- `syn_ok` input 1: all parity checks satisfied; valid on the last VN cycle.
- `out_ready` input 1: downstream can accept a full codeword burst.
- `fsm` output 4: one-hot phase. [0]=LOAD, [1]=CN, [2]=VN, [3]=OUT; 4'b0000 = IDLE.
- `busy` output 1: high whenever not in IDLE.
- `done` output 1: one-cycle pulse when a codeword completes.
- `dec_ok` output 1: the last codeword terminated on `syn_ok`; held until the next `start` is accepted.
- `iter_cnt` output IT_WID: number of iterations completed for the current or last codeword.

## Operation
- States are IDLE, LOAD, CN, VN, WAIT_OUT and OUT. WAIT_OUT also drives `fsm`=0, with `busy`=1.
- IDLE → LOAD when `start`=1.
  - Latch `rate` into `rate_q` and `max_iter` into `lim_q` (0 becomes 1).
  - Clear `iter_cnt` and `dec_ok`.
- LOAD:
  - The beat counter increments on each `in_valid`.
  - Required beats: 128 when `rate_q`=0, 192 when `rate_q`=1.
  - When the final beat is accepted, go to CN on the next cycle. Gaps in `in_valid` stall the count.
- CN: hold for exactly `CN_CYC` cycles, then go to VN.
- VN: hold for exactly `VN_CYC` cycles. On the last VN cycle:
  - `iter_cnt` increments.
  - If `syn_ok`=1: set `dec_ok`=1 and go to WAIT_OUT.
  - Else if the incremented `iter_cnt` equals `lim_q`: go to WAIT_OUT with `dec_ok`=0.
  - Else: go to CN.
- WAIT_OUT: go to OUT on the first cycle `out_ready`=1. The transition happens in that same cycle, so `fsm[3]` rises next cycle.
- OUT:
  - Hold for `out_max`+1 cycles, where `out_max` = 4607 (`rate_q`=0) or 6911 (`rate_q`=1). Use a 13-bit phase counter.
  - After the last cycle, go to IDLE and pulse `done`.
  - Once entered, OUT cannot be stalled.
- `rate` and `max_iter` changes outside the IDLE→LOAD transition have no effect.
- `start` while `busy` is ignored; it is not queued.

## Timing
- Reset values: `fsm`=0, `busy`=0, `done`=0, `dec_ok`=0, `iter_cnt`=0. All phase counters = 0, state = IDLE.
- All outputs are registered; no combinational input-to-output path.
- `start` high at edge N: `fsm`=4'b0001 and `busy`=1 from edge N+1.
- Each phase's `fsm` bit is high for exactly its length in cycles: CN=`CN_CYC`, VN=`VN_CYC`, OUT=`out_max`+1. There are no idle gaps between CN and VN, or between VN and CN.
- The last `fsm[3]` cycle is at edge M. At M+1: `fsm`=0 and `done`=1. At M+2: `done`=0 and `busy`=0.
- A new `start` is accepted at M+1 at the earliest, i.e. when state is already IDLE and `done` is high.
- Reset mid-operation: every output returns to its reset value immediately (asynchronous). No partial OUT burst resumes after reset.
- The phase counter is cleared on every state transition, so wrap-around never carries across phases.

## Structure
- Shared decoder package holds:
  - The `fsm` bit indices (LOAD=0, CN=1, VN=2, OUT=3).
  - Beat counts 128/192.
  - Output lengths 4608/6912.
  - The rate encoding.
  - The `rate_q`-selected length helper, shared with `rd_seq`.
- A single `phase_cnt` sub-module: a 13-bit counter with clear, enable and a terminal-count compare against a supplied limit. It is instantiated once and reused by every phase.

## Test plan
- Rate 0, `max_iter`=3, `syn_ok`=0, continuous `in_valid`, `out_ready`=1:
  - LOAD 128 cycles, then 3×(CN 96 + VN 128), then OUT 4608 cycles.
  - `done` pulses once; `iter_cnt`=3, `dec_ok`=0.
- Rate 1, `syn_ok`=1 on the first VN end: `iter_cnt`=1, `dec_ok`=1, OUT lasts exactly 6912 cycles.
- `in_valid` toggling every other cycle, rate 0: LOAD lasts 255 cycles, CN starts after the 128th beat.
- `out_ready` held low 50 cycles after the last VN: `fsm`=0 and `busy`=1 for 50 cycles, then OUT for the full 4608 cycles.
- `max_iter`=0: exactly one iteration, then OUT. A `start` pulse during CN is ignored.
- `reset_n` asserted mid-OUT at cycle 2000: `fsm`=0 and `busy`=0 immediately. After release, a fresh `start` runs normally.
